// File: rtl/frequency_generator_pkg.sv
// Shared definitions for the frequency generator.
// Holds the FSM state encoding, the default parameter values and the
// divider step-count helper used to size the serial divide.
package frequency_generator_pkg;

   localparam int CLOCK_HZ_DEF   = 1_000_000;
   localparam int INPUT_BITS_DEF = 20;
   localparam int ACC_BITS_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      UPDATE = 2'd2
   } fg_state_t;

   // One quotient bit per clock over the whole (Hz << ACC_BITS) dividend.
   function automatic int div_steps(input int input_bits, input int acc_bits);
      return input_bits + acc_bits;
   endfunction

endpackage

// File: rtl/frequency_generator_divider.sv
// serial_divider: generic restoring shift-subtract divider.
// Ports:
//   Clock       system clock, posedge
//   Reset       asynchronous active-low reset
//   Start_i     one-cycle strobe: capture Dividend_i/Divisor_i and begin
//   Dividend_i  unsigned dividend
//   Divisor_i   unsigned divisor (must be non-zero)
//   Quotient_o  low QUOTIENT_BITS of the quotient, valid while Done_o=1 and
//               held until the next Start_i
//   Done_o      one-cycle pulse, quotient valid
// The first quotient bit is produced on the Start_i clock itself, so a
// DIVIDEND_BITS-bit divide completes DIVIDEND_BITS clocks after Start_i and
// Done_o is high on the cycle after the final step.
module serial_divider #(
   parameter int DIVIDEND_BITS = 52,
   parameter int DIVISOR_BITS  = 20,
   parameter int QUOTIENT_BITS = 32
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Start_i,
   input  logic [DIVIDEND_BITS-1:0] Dividend_i,
   input  logic [DIVISOR_BITS-1:0]  Divisor_i,
   output logic [QUOTIENT_BITS-1:0] Quotient_o,
   output logic                     Done_o
);

   localparam int CW = $clog2(DIVIDEND_BITS + 1);

   // shift_q starts as the dividend; quotient bits shift in from the right
   // as dividend bits shift out the top, so it ends up holding the quotient.
   logic [DIVIDEND_BITS-1:0] shift_q, shift_in, shift_next;
   logic [DIVISOR_BITS-1:0]  rem_q, rem_in, rem_next;
   logic [DIVISOR_BITS-1:0]  divisor_q, divisor_in;
   logic [DIVISOR_BITS:0]    trial;
   logic                     q_bit;
   logic [CW-1:0]            steps_left;
   logic                     done_q;

   always_comb begin
      rem_in     = Start_i ? '0 : rem_q;
      shift_in   = Start_i ? Dividend_i : shift_q;
      divisor_in = Start_i ? Divisor_i : divisor_q;
      trial      = {rem_in, shift_in[DIVIDEND_BITS-1]};
      q_bit      = 1'b0;
      rem_next   = trial[DIVISOR_BITS-1:0];
      if (trial >= {1'b0, divisor_in}) begin
         q_bit    = 1'b1;
         // True difference is below the divisor, so the low bits are exact.
         rem_next = trial[DIVISOR_BITS-1:0] - divisor_in;
      end
      shift_next = {shift_in[DIVIDEND_BITS-2:0], q_bit};
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         shift_q    <= '0;
         rem_q      <= '0;
         divisor_q  <= '0;
         steps_left <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (Start_i) begin
            shift_q    <= shift_next;
            rem_q      <= rem_next;
            divisor_q  <= Divisor_i;
            steps_left <= CW'(DIVIDEND_BITS - 1);
         end else if (steps_left != '0) begin
            shift_q    <= shift_next;
            rem_q      <= rem_next;
            steps_left <= steps_left - 1'b1;
            if (steps_left == CW'(1)) begin
               done_q <= 1'b1;
            end
         end
      end
   end

   assign Quotient_o = shift_q[QUOTIENT_BITS-1:0];
   assign Done_o     = done_q;

endmodule

// File: rtl/frequency_generator.sv
// frequency_generator: programmable square-wave source (NCO).
// Ports:
//   Clock          system clock, posedge
//   Reset          asynchronous active-low reset
//   Enable_i       1 = run accumulator; 0 = accumulator/outputs held at 0
//   Load_i         one-cycle strobe: capture FrequencyHz_i, start divide
//   FrequencyHz_i  requested frequency in Hz (clamped to CLOCK_HZ/2)
//   Busy_o         high while the increment is being computed
//   Signal_o       square wave = registered accumulator MSB
//   Tick_o         one-cycle pulse on each rising edge of Signal_o
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for Load_i; current increment drives the NCO
// DIVIDE | serial divider computing floor(Hz * 2^ACC_BITS / CLOCK_HZ)
// UPDATE | quotient copied into the increment register on this clock
module frequency_generator
   import frequency_generator_pkg::*;
#(
   parameter int CLOCK_HZ   = CLOCK_HZ_DEF,
   parameter int INPUT_BITS = INPUT_BITS_DEF,
   parameter int ACC_BITS   = ACC_BITS_DEF
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable_i,
   input  logic                  Load_i,
   input  logic [INPUT_BITS-1:0] FrequencyHz_i,
   output logic                  Busy_o,
   output logic                  Signal_o,
   output logic                  Tick_o
);

   localparam int DIV_STEPS    = div_steps(INPUT_BITS, ACC_BITS);
   localparam int DIVISOR_BITS = $clog2(CLOCK_HZ + 1);
   localparam int HALF_HZ      = CLOCK_HZ / 2;
   localparam logic [INPUT_BITS-1:0]   HALF_HZ_V  = INPUT_BITS'(HALF_HZ);
   localparam logic [DIVISOR_BITS-1:0] CLOCK_HZ_V = DIVISOR_BITS'(CLOCK_HZ);

   fg_state_t state, state_next;

   logic                  div_start;
   logic                  div_done;
   logic [ACC_BITS-1:0]   quotient;
   logic [INPUT_BITS-1:0] hz_clamped;
   logic [DIV_STEPS-1:0]  dividend;

   logic [ACC_BITS-1:0]   increment;
   logic [ACC_BITS-1:0]   accumulator;
   logic [ACC_BITS-1:0]   acc_next;
   logic                  signal_q;
   logic                  tick_q;

   // Capping at CLOCK_HZ/2 keeps the quotient within ACC_BITS.
   assign hz_clamped = (FrequencyHz_i > HALF_HZ_V) ? HALF_HZ_V : FrequencyHz_i;
   assign dividend   = {hz_clamped, {ACC_BITS{1'b0}}};

   serial_divider #(
      .DIVIDEND_BITS (DIV_STEPS),
      .DIVISOR_BITS  (DIVISOR_BITS),
      .QUOTIENT_BITS (ACC_BITS)
   ) u_divider (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start_i    (div_start),
      .Dividend_i (dividend),
      .Divisor_i  (CLOCK_HZ_V),
      .Quotient_o (quotient),
      .Done_o     (div_done)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      case (state)
         IDLE: begin
            if (Load_i) begin
               div_start  = 1'b1;
               state_next = DIVIDE;
            end
         end
         DIVIDE: begin
            if (div_done) begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign Busy_o = (state != IDLE);

   // Accumulator is left untouched at the update so the phase carries over.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         increment <= '0;
      end else if (state == UPDATE) begin
         increment <= quotient;
      end
   end

   assign acc_next = accumulator + increment;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         accumulator <= '0;
         signal_q    <= 1'b0;
         tick_q      <= 1'b0;
      end else if (Enable_i) begin
         accumulator <= acc_next;
         signal_q    <= acc_next[ACC_BITS-1];
         tick_q      <= acc_next[ACC_BITS-1] & ~signal_q;
      end else begin
         accumulator <= '0;
         signal_q    <= 1'b0;
         tick_q      <= 1'b0;
      end
   end

   assign Signal_o = signal_q;
   assign Tick_o   = tick_q;

endmodule
